mac_layer_seq: RTL and testbench

Sequencer for one fully-connected SNN layer built around the shared 8x8 signed MAC, which has a 26-bit accumulator and a synchronous clear (clr_n).
- Walks input and weight memory addresses for each output neuron.
- Drives the MAC clear so exactly NUM_IN products are summed per neuron.
- Scales and saturates the final sum to 8 bits, then writes it to the output memory.
- Sits between the layer's input/weight RAMs (1-cycle synchronous read) and the next layer's input RAM.

---
 rtl/mac_layer_seq.sv | 203 ++++++++++++++++++++
 tb/tb_mac_layer_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mac_layer_seq.sv
// Address/clear sequencer for one fully-connected SNN layer around a shared 8x8 MAC.
// Optional build macro RELU_EN clamps negative neuron results to zero after saturation.
module mac_layer_seq #(
    parameter int NUM_IN     = 784,
    parameter int NUM_OUT    = 32,
    parameter int FRAC_SHIFT = 7,
    parameter int IN_AW      = $clog2(NUM_IN),
    parameter int WT_AW      = $clog2(NUM_IN * NUM_OUT),
    parameter int OUT_AW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [25:0]       acc,
    output logic [IN_AW-1:0]  in_addr,
    output logic [WT_AW-1:0]  wt_addr,
    output logic              rd_en,
    output logic              mac_clr_n,
    output logic [OUT_AW-1:0] out_addr,
    output logic [7:0]        out_data,
    output logic              out_we,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(NUM_IN + 1);
    localparam logic [CW-1:0]     K_LAST  = CW'(NUM_IN);
    localparam logic [CW-1:0]     K_PRE   = CW'(NUM_IN - 1);
    localparam logic [OUT_AW-1:0] N_LAST  = OUT_AW'(NUM_OUT - 1);
    localparam logic [WT_AW-1:0]  WT_STEP = WT_AW'(NUM_IN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACC  = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t              state_r, state_nx_s;
    logic [CW-1:0]       k_r, k_nx_s, k_inc_s;
    logic [OUT_AW-1:0]   n_r, n_nx_s;
    logic [WT_AW-1:0]    base_r, base_nx_s;
    logic [IN_AW-1:0]    in_addr_nx_s;
    logic [WT_AW-1:0]    wt_addr_nx_s;
    logic                rd_en_nx_s;
    logic                clr_n_nx_s;
    logic [OUT_AW-1:0]   out_addr_nx_s;
    logic [7:0]          out_data_nx_s;
    logic                out_we_nx_s;
    logic                busy_nx_s;
    logic                done_nx_s;

    // Scale the accumulator down and clamp it into the signed 8-bit output range.
    function automatic logic [7:0] sat8(input logic signed [25:0] a);
        logic signed [25:0] s;
        logic [7:0]         r;
        s = a >>> FRAC_SHIFT;
`ifdef RELU_EN
        if (s > 26'sd127) begin
            r = 8'h7F;
        end else if (s < 26'sd0) begin
            r = 8'h00;
        end else begin
            r = s[7:0];
        end
`else
        if (s > 26'sd127) begin
            r = 8'h7F;
        end else if (s < -26'sd128) begin
            r = 8'h80;
        end else begin
            r = s[7:0];
        end
`endif
        return r;
    endfunction

    // Next-state logic; every output is computed one cycle ahead so the ports come straight from flops.
    always_comb begin
        state_nx_s    = state_r;
        k_inc_s       = k_r + CW'(1);
        k_nx_s        = k_r;
        n_nx_s        = n_r;
        base_nx_s     = base_r;
        in_addr_nx_s  = in_addr;
        wt_addr_nx_s  = wt_addr;
        rd_en_nx_s    = 1'b0;
        clr_n_nx_s    = 1'b0;
        out_addr_nx_s = out_addr;
        out_data_nx_s = out_data;
        out_we_nx_s   = 1'b0;
        busy_nx_s     = busy;
        done_nx_s     = 1'b0;

        case (state_r)
            IDLE: begin
                // done high means the previous layer is just retiring; a start here is dropped
                if (start && !done) begin
                    state_nx_s   = LOAD;
                    busy_nx_s    = 1'b1;
                    rd_en_nx_s   = 1'b1;
                    in_addr_nx_s = '0;
                    wt_addr_nx_s = '0;
                    n_nx_s       = '0;
                    base_nx_s    = '0;
                    k_nx_s       = '0;
                end else begin
                    busy_nx_s    = 1'b0;
                end
            end
            LOAD: begin
                state_nx_s   = ACC;
                k_nx_s       = CW'(1);
                clr_n_nx_s   = 1'b1;
                rd_en_nx_s   = 1'b1;
                in_addr_nx_s = IN_AW'(1);
                wt_addr_nx_s = base_r + WT_AW'(1);
            end
            ACC: begin
                if (k_r == K_LAST) begin
                    state_nx_s = WB;
                    // WB already fetches address 0 of the next neuron
                    if (n_r != N_LAST) begin
                        rd_en_nx_s   = 1'b1;
                        in_addr_nx_s = '0;
                        wt_addr_nx_s = base_r + WT_STEP;
                    end else begin
                        rd_en_nx_s   = 1'b0;
                    end
                end else begin
                    k_nx_s     = k_inc_s;
                    clr_n_nx_s = 1'b1;
                    if (k_r < K_PRE) begin
                        rd_en_nx_s   = 1'b1;
                        in_addr_nx_s = IN_AW'(k_inc_s);
                        wt_addr_nx_s = base_r + WT_AW'(k_inc_s);
                    end else begin
                        rd_en_nx_s   = 1'b0;
                    end
                end
            end
            WB: begin
                out_data_nx_s = sat8($signed(acc));
                out_addr_nx_s = n_r;
                out_we_nx_s   = 1'b1;
                if (n_r != N_LAST) begin
                    state_nx_s   = ACC;
                    n_nx_s       = n_r + OUT_AW'(1);
                    base_nx_s    = base_r + WT_STEP;
                    k_nx_s       = CW'(1);
                    clr_n_nx_s   = 1'b1;
                    rd_en_nx_s   = 1'b1;
                    in_addr_nx_s = IN_AW'(1);
                    wt_addr_nx_s = base_r + WT_STEP + WT_AW'(1);
                end else begin
                    state_nx_s   = IDLE;
                    busy_nx_s    = 1'b0;
                    done_nx_s    = 1'b1;
                    in_addr_nx_s = '0;
                    wt_addr_nx_s = '0;
                end
            end
            default: begin
                state_nx_s = IDLE;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            k_r       <= '0;
            n_r       <= '0;
            base_r    <= '0;
            in_addr   <= '0;
            wt_addr   <= '0;
            rd_en     <= 1'b0;
            mac_clr_n <= 1'b0;
            out_addr  <= '0;
            out_data  <= 8'h00;
            out_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            k_r       <= k_nx_s;
            n_r       <= n_nx_s;
            base_r    <= base_nx_s;
            in_addr   <= in_addr_nx_s;
            wt_addr   <= wt_addr_nx_s;
            rd_en     <= rd_en_nx_s;
            mac_clr_n <= clr_n_nx_s;
            out_addr  <= out_addr_nx_s;
            out_data  <= out_data_nx_s;
            out_we    <= out_we_nx_s;
            busy      <= busy_nx_s;
            done      <= done_nx_s;
        end
    end

endmodule

// File: tb/tb_mac_layer_seq.sv
// Directed bench for mac_layer_seq: two instances (FRAC_SHIFT 0 and 7) share RAM contents,
// each with its own synchronous-read RAM ports and 26-bit MAC model.
module tb_mac_layer_seq;

    localparam int NI = 4;
    localparam int NO = 2;
`ifdef RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0] in_mem [0:NI-1];
    logic signed [7:0] wt_mem [0:NI*NO-1];

    int n_vec  = 0;
    int n_fail = 0;

    logic [25:0] acc0 = '0, acc7 = '0;
    logic [1:0]  in_addr0, in_addr7;
    logic [2:0]  wt_addr0, wt_addr7;
    logic        rd_en0, rd_en7, clr0, clr7;
    logic [0:0]  out_addr0, out_addr7;
    logic [7:0]  out_data0, out_data7;
    logic        out_we0, out_we7, busy0, busy7, done0, done7;

    logic signed [7:0]  in_q0 = '0, wt_q0 = '0, in_q7 = '0, wt_q7 = '0;
    logic signed [15:0] p0, p7;
    assign p0 = in_q0 * wt_q0;
    assign p7 = in_q7 * wt_q7;

    mac_layer_seq #(.NUM_IN(NI), .NUM_OUT(NO), .FRAC_SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .acc(acc0),
        .in_addr(in_addr0), .wt_addr(wt_addr0), .rd_en(rd_en0), .mac_clr_n(clr0),
        .out_addr(out_addr0), .out_data(out_data0), .out_we(out_we0),
        .busy(busy0), .done(done0)
    );

    mac_layer_seq #(.NUM_IN(NI), .NUM_OUT(NO), .FRAC_SHIFT(7)) u_dut7 (
        .clk(clk), .rst(rst), .start(start), .acc(acc7),
        .in_addr(in_addr7), .wt_addr(wt_addr7), .rd_en(rd_en7), .mac_clr_n(clr7),
        .out_addr(out_addr7), .out_data(out_data7), .out_we(out_we7),
        .busy(busy7), .done(done7)
    );

    // RAM read ports and MAC for each instance
    always @(posedge clk) begin
        if (rd_en0) begin
            in_q0 <= in_mem[in_addr0];
            wt_q0 <= wt_mem[wt_addr0];
        end
        if (!clr0) acc0 <= '0;
        else       acc0 <= acc0 + {{10{p0[15]}}, p0};
        if (rd_en7) begin
            in_q7 <= in_mem[in_addr7];
            wt_q7 <= wt_mem[wt_addr7];
        end
        if (!clr7) acc7 <= '0;
        else       acc7 <= acc7 + {{10{p7[15]}}, p7};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_in_addr", 32'(in_addr0), 32'd0);
        check("rst_wt_addr", 32'(wt_addr0), 32'd0);
        check("rst_rd_en", 32'(rd_en0), 32'd0);
        check("rst_clr_n", 32'(clr0), 32'd0);
        check("rst_out_addr", 32'(out_addr0), 32'd0);
        check("rst_out_data", 32'(out_data0), 32'd0);
        check("rst_out_we", 32'(out_we0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_out_we7", 32'(out_we7), 32'd0);
    endtask

    // Expected per-cycle control pattern, bit c = cycle c after the start edge
    logic [13:0] rd_t, clr_t, busy_t, we_t, done_t;
    int wt_t [0:13];

    task automatic run_layer(input logic [7:0] e0a, input logic [7:0] e0b,
                             input logic [7:0] e7a, input logic [7:0] e7b,
                             input bit hold_start);
        start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 13; c++) begin
            check("rd_en", 32'(rd_en0), 32'(rd_t[c]));
            check("mac_clr_n", 32'(clr0), 32'(clr_t[c]));
            check("busy", 32'(busy0), 32'(busy_t[c]));
            check("out_we", 32'(out_we0), 32'(we_t[c]));
            check("done", 32'(done0), 32'(done_t[c]));
            if (rd_t[c]) begin
                check("wt_addr", 32'(wt_addr0), 32'(wt_t[c]));
                check("in_addr", 32'(in_addr0), 32'(wt_t[c] % NI));
            end
            if (we_t[c]) begin
                check("out_addr", 32'(out_addr0), (c == 12) ? 32'd1 : 32'd0);
                check("out_data_fs0", 32'(out_data0), (c == 12) ? 32'(e0b) : 32'(e0a));
                check("out_we_fs7", 32'(out_we7), 32'd1);
                check("out_data_fs7", 32'(out_data7), (c == 12) ? 32'(e7b) : 32'(e7a));
            end
            start = hold_start && (c < 13);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        rd_t   = 14'h03DE;
        clr_t  = 14'h07BC;
        busy_t = 14'h0FFE;
        we_t   = 14'h1080;
        done_t = 14'h1000;
        wt_t   = '{0, 0, 1, 2, 3, 0, 4, 5, 6, 7, 0, 0, 0, 0};

        // reset
        repeat (2) @(negedge clk);
        check_reset();
        rst = 1'b0;
        @(negedge clk);

        // all inputs 1, weights 3 -> 12 per neuron
        for (int i = 0; i < NI; i++) in_mem[i] = 8'sd1;
        for (int i = 0; i < NI*NO; i++) wt_mem[i] = 8'sd3;
        run_layer(8'h0C, 8'h0C, 8'h00, 8'h00, 1'b0);

        // saturation extremes, start held high for the whole run
        for (int i = 0; i < NI; i++) begin
            in_mem[i]      = 8'sd127;
            wt_mem[i]      = 8'sd127;
            wt_mem[NI + i] = -8'sd128;
        end
        run_layer(8'h7F, RELU ? 8'h00 : 8'h80, 8'h7F, RELU ? 8'h00 : 8'h80, 1'b1);
        check("no_restart_busy", 32'(busy0), 32'd0);

        // sum 1280 and -300
        for (int i = 0; i < NI; i++) begin
            in_mem[i] = 8'sd10;
            wt_mem[i] = 8'sd32;
        end
        wt_mem[4] = -8'sd8;
        wt_mem[5] = -8'sd8;
        wt_mem[6] = -8'sd7;
        wt_mem[7] = -8'sd7;
        run_layer(8'h7F, RELU ? 8'h00 : 8'h80, 8'h0A, RELU ? 8'h00 : 8'hFD, 1'b0);

        // distinct inputs/weights: sums -2 and 70
        for (int i = 0; i < NI; i++) begin
            in_mem[i]      = 8'(i + 1);
            wt_mem[i]      = (i % 2 == 0) ? 8'sd1 : -8'sd1;
            wt_mem[NI + i] = 8'(i + 5);
        end
        run_layer(RELU ? 8'h00 : 8'hFE, 8'h46, RELU ? 8'h00 : 8'hFF, 8'h00, 1'b0);

        // reset during neuron 1 accumulation
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset();
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            check("post_rst_we", 32'(out_we0), 32'd0);
            check("post_rst_done", 32'(done0), 32'd0);
            check("post_rst_busy", 32'(busy0), 32'd0);
        end

        // full layer after abandoned run
        for (int i = 0; i < NI; i++) begin
            in_mem[i] = 8'sd10;
            wt_mem[i] = 8'sd32;
        end
        wt_mem[4] = -8'sd8;
        wt_mem[5] = -8'sd8;
        wt_mem[6] = -8'sd7;
        wt_mem[7] = -8'sd7;
        run_layer(8'h7F, RELU ? 8'h00 : 8'h80, 8'h0A, RELU ? 8'h00 : 8'hFD, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
